// File: rtl/i2s_tx.sv
// ------------------------------------------------------------------------
// i2s_tx - I2S transmitter, divides clk into bclk/ws and shifts out one
// stereo pair per frame with the standard one-bit delay.   Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module i2s_tx #(
  parameter int DATA_W = 18,
  parameter int SLOT_W = 32,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] d_left,
  input  logic [DATA_W-1:0] d_right,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              ws,
  output logic              sd,
  output logic              frame_start,
  output logic              underrun
);

  localparam int DIV_W = $clog2(DIV);
  localparam int B_W   = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);
  localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_W);
  localparam logic [B_W-1:0]   L_LAST   = B_W'(DATA_W);
  localparam logic [B_W-1:0]   R_FIRST  = B_W'(SLOT_W + 1);
  localparam logic [B_W-1:0]   R_LAST   = B_W'(SLOT_W + DATA_W);

  logic [DIV_W-1:0]  div_q;
  logic              bclk_q;
  logic              started_q;
  logic [B_W-1:0]    b_q;
  logic [B_W-1:0]    b_d;
  logic              ws_q;
  logic              sd_q;
  logic              fs_q;
  logic              ur_q;
  logic              full_q;
  logic [DATA_W-1:0] hold_l_q;
  logic [DATA_W-1:0] hold_r_q;
  logic [DATA_W-1:0] sh_l_q;
  logic [DATA_W-1:0] sh_r_q;

  logic w_div_wrap;
  logic w_fall;
  logic w_wrap;
  logic w_accept;

  assign w_div_wrap = (div_q == DIV_LAST);
  assign w_fall     = enable && bclk_q && w_div_wrap;
  assign w_accept   = sample_valid && !full_q;

  // The first falling edge after enable enters b=0 rather than advancing.
  always_comb begin
    b_d = '0;
    if (started_q && (b_q != B_LAST)) begin
      b_d = b_q + 1'b1;
    end
  end

  assign w_wrap = w_fall && (b_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      started_q <= 1'b0;
      b_q       <= '0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
      full_q    <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      sh_l_q    <= '0;
      sh_r_q    <= '0;
    end else begin
      // Transfer uses the pre-edge full flag; a same-cycle accept waits a frame.
      if (w_wrap && full_q) begin
        full_q <= 1'b0;
      end else if (w_accept) begin
        full_q   <= 1'b1;
        hold_l_q <= d_left;
        hold_r_q <= d_right;
      end
      fs_q <= w_wrap;
      ur_q <= w_wrap && !full_q;

      if (!enable) begin
        div_q     <= '0;
        bclk_q    <= 1'b0;
        started_q <= 1'b0;
        b_q       <= '0;
        ws_q      <= 1'b0;
        sd_q      <= 1'b0;
        sh_l_q    <= '0;
        sh_r_q    <= '0;
      end else begin
        div_q <= w_div_wrap ? '0 : div_q + 1'b1;
        if (w_div_wrap) begin
          bclk_q <= ~bclk_q;
        end
        if (w_fall) begin
          started_q <= 1'b1;
          b_q       <= b_d;
          ws_q      <= (b_d >= B_SLOT);
          if (b_d == '0) begin
            sh_l_q <= full_q ? hold_l_q : '0;
            sh_r_q <= full_q ? hold_r_q : '0;
            sd_q   <= 1'b0;
          end else if (b_d <= L_LAST) begin
            sd_q   <= sh_l_q[DATA_W-1];
            sh_l_q <= {sh_l_q[DATA_W-2:0], 1'b0};
          end else if ((b_d >= R_FIRST) && (b_d <= R_LAST)) begin
            sd_q   <= sh_r_q[DATA_W-1];
            sh_r_q <= {sh_r_q[DATA_W-2:0], 1'b0};
          end else begin
            sd_q <= 1'b0;
          end
        end
      end
    end
  end

  assign sample_ready = !full_q;
  assign bclk         = bclk_q;
  assign ws           = ws_q;
  assign sd           = sd_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ------------------------------------------------------------------------
// tb_i2s_tx - directed self-checking bench for i2s_tx (DIV=2, SLOT_W=32,
// DATA_W=18).   Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_i2s_tx;

  localparam int DW = 18;
  localparam int SW = 32;
  localparam int DV = 2;

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          enable       = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] d_left       = '0;
  logic [DW-1:0] d_right      = '0;
  logic          sample_ready;
  logic          bclk;
  logic          ws;
  logic          sd;
  logic          frame_start;
  logic          underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  i2s_tx #(
    .DATA_W(DW),
    .SLOT_W(SW),
    .DIV   (DV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .d_left      (d_left),
    .d_right     (d_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bclk        (bclk),
    .ws          (ws),
    .sd          (sd),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n;
    n            = 0;
    d_left       = l;
    d_right      = r;
    sample_valid = 1'b1;
    while (!sample_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("push_ready_timeout", 64'(sample_ready), 64'd1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_fs(output int n, output int nrise);
    n     = 0;
    nrise = 0;
    do begin
      @(negedge clk);
      n++;
      if (bclk && nrise == 0) nrise = n;
    end while (!frame_start && n < 2000);
    check("frame_start_seen", 64'(frame_start), 64'd1);
  endtask

  // Samples ws/sd at each of the 64 bclk rising edges following a frame_start.
  task automatic capture(output logic [63:0] sdw, output logic [63:0] wsw, output int per);
    logic prev;
    int   n;
    int   c0;
    prev = bclk;
    per  = 0;
    c0   = 0;
    sdw  = '0;
    wsw  = '0;
    for (int i = 0; i < 64; i++) begin
      n = 0;
      forever begin
        @(negedge clk);
        n++;
        if (bclk && !prev) break;
        prev = bclk;
        if (n > 100) break;
      end
      prev = bclk;
      if (n > 100) begin
        check("bclk_rise_timeout", 64'(n), 64'd0);
        return;
      end
      sdw[i] = sd;
      wsw[i] = ws;
      if (i == 0) c0 = cyc;
      if (i == 1) per = cyc - c0;
    end
  endtask

  task automatic check_frame(input string tag, input logic [DW-1:0] el, input logic [DW-1:0] er,
                             output int per);
    logic [63:0]   s;
    logic [63:0]   w;
    logic [63:0]   pad;
    logic [DW-1:0] gl;
    logic [DW-1:0] gr;
    capture(s, w, per);
    pad = s;
    for (int j = 0; j < DW; j++) begin
      gl[DW-1-j]   = s[1+j];
      gr[DW-1-j]   = s[SW+1+j];
      pad[1+j]     = 1'b0;
      pad[SW+1+j]  = 1'b0;
    end
    check({tag, "_left"}, 64'(gl), 64'(el));
    check({tag, "_right"}, 64'(gr), 64'(er));
    check({tag, "_pad_zero"}, pad, 64'd0);
    check({tag, "_ws"}, w, 64'hFFFF_FFFF_0000_0000);
  endtask

  initial begin
    int n;
    int nr;
    int per;
    int nbad;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bclk, ws, sd, frame_start, underrun, sample_ready}), 64'b000001);
    reset = 1'b0;

    nbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bclk || ws || sd || frame_start || underrun || !sample_ready) nbad++;
    end
    check("idle_quiet", 64'(nbad), 64'd0);

    push(18'h2AAAA, 18'h15555);
    check("ready_after_load", 64'(sample_ready), 64'd0);
    enable = 1'b1;
    wait_fs(n, nr);
    check("fs_latency", 64'(n), 64'd4);
    check("first_bclk_rise", 64'(nr), 64'd2);
    check("f1_underrun", 64'(underrun), 64'd0);
    check("ready_after_xfer", 64'(sample_ready), 64'd1);
    check_frame("f1", 18'h2AAAA, 18'h15555, per);
    check("bclk_period", 64'(per), 64'd4);

    wait_fs(n, nr);
    check("f2_underrun", 64'(underrun), 64'd1);
    fork
      check_frame("f2", 18'h00000, 18'h00000, per);
      push(18'h3FFFF, 18'h00001);
    join

    wait_fs(n, nr);
    check("f3_underrun", 64'(underrun), 64'd0);
    check_frame("f3", 18'h3FFFF, 18'h00001, per);

    fork
      begin
        for (int k = 0; k < 4; k++) push(18'h10000 + 18'(k), 18'h20000 + 18'(k));
      end
      begin
        int fn;
        int fr;
        int fp;
        for (int k = 0; k < 4; k++) begin
          wait_fs(fn, fr);
          check("stream_underrun", 64'(underrun), 64'd0);
          check_frame("stream", 18'h10000 + 18'(k), 18'h20000 + 18'(k), fp);
        end
      end
    join

    // Valid arrives in the very clk of the b=0 transition with holding empty.
    @(negedge clk);
    fork
      push(18'h1F0F0, 18'h0A5A5);
      begin
        int sn;
        int sr;
        int sp;
        wait_fs(sn, sr);
        check("sim_underrun", 64'(underrun), 64'd1);
        check_frame("sim_e", 18'h00000, 18'h00000, sp);
      end
    join
    wait_fs(n, nr);
    check("sim_f_underrun", 64'(underrun), 64'd0);
    check_frame("sim_f", 18'h1F0F0, 18'h0A5A5, per);

    wait_fs(n, nr);
    check("g_underrun", 64'(underrun), 64'd1);
    push(18'h00003, 18'h00005);
    repeat (160) @(negedge clk);
    check("b40_ws", 64'(ws), 64'd1);
    check("b40_ready", 64'(sample_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset", 64'({bclk, ws, sd, frame_start, underrun, sample_ready}), 64'b000001);
    reset = 1'b0;
    wait_fs(n, nr);
    check("restart_fs_latency", 64'(n), 64'd4);
    check("restart_underrun", 64'(underrun), 64'd1);
    check_frame("restart", 18'h00000, 18'h00000, per);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
